// File: rtl/axi_read_burst_splitter_pkg.sv
// Shared constants, FSM encoding and the burst-sizing helper for the AXI read burst splitter.
// The helper clips a request to the burst limit and to the next 4 KB boundary.
package axi_read_burst_splitter_pkg;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam int         BOUNDARY_BYTES = 4096;
   localparam int         CHUNK_W        = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Beats in the next burst: min(left, max_len, beats to the next 4 KB boundary).
   // addr_lo is word aligned, so the boundary term is always 1..1024.
   function automatic logic [CHUNK_W-1:0] burst_chunk(
      input logic [11:0]        addr_lo,
      input logic [31:0]        left,
      input logic [CHUNK_W-1:0] max_len
   );
      logic [12:0] to_boundary;
      logic [12:0] limit;
      to_boundary = (13'(BOUNDARY_BYTES) - {1'b0, addr_lo}) >> 2;
      limit       = (to_boundary < {4'd0, max_len}) ? to_boundary : {4'd0, max_len};
      if (left < {19'd0, limit})
         burst_chunk = left[CHUNK_W-1:0];
      else
         burst_chunk = limit[CHUNK_W-1:0];
   endfunction

endpackage

// File: rtl/axi_read_burst_splitter_burst_len_fifo.sv
// FIFO of issued burst lengths; follows the beats of the oldest burst and
// flags the beat that completes it, which retires that entry.
module axi_read_burst_splitter_burst_len_fifo
   import axi_read_burst_splitter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CHUNK_W,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_count,
   input  logic             beat,
   output logic             final_beat,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [WIDTH-1:0] head_cnt_reg;
   logic             empty;
   logic             head_beat;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty      = (count_reg == '0);
   assign head_beat  = beat && !empty;
   assign final_beat = head_beat && ((head_cnt_reg + WIDTH'(1)) == mem_reg[rd_ptr_reg]);
   assign count      = count_reg;

   // Storage carries no reset: an entry is only read while it is occupied.
   always_ff @(posedge clk) begin
      if (push)
         mem_reg[wr_ptr_reg] <= push_count;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         head_cnt_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (final_beat)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (head_beat)
            head_cnt_reg <= final_beat ? '0 : head_cnt_reg + WIDTH'(1);
         if (push && !final_beat)
            count_reg <= count_reg + CNT_W'(1);
         else if (!push && final_beat)
            count_reg <= count_reg - CNT_W'(1);
      end
   end

endmodule

// File: rtl/axi_read_burst_splitter.sv
// Splits one long read into legal AXI INCR bursts (length- and 4 KB-limited),
// passes read data straight through and pulses xfer_done when every beat has returned.
module axi_read_burst_splitter
   import axi_read_burst_splitter_pkg::*;
#(
   parameter int AXI_AWIDTH      = 32,
   parameter int AXI_DWIDTH      = 32,
   parameter int MAX_BURST_LEN   = 256,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up_req_valid,
   output logic                  up_req_ready,
   input  logic [AXI_AWIDTH-1:0] up_addr,
   input  logic [31:0]           up_len,
   output logic [AXI_DWIDTH-1:0] up_data,
   output logic                  up_data_valid,
   input  logic                  up_data_ready,
   output logic                  xfer_done,
   output logic                  dn_req_valid,
   input  logic                  dn_req_ready,
   output logic [AXI_AWIDTH-1:0] dn_addr,
   output logic [31:0]           dn_len,
   output logic [2:0]            dn_size,
   output logic [1:0]            dn_burst,
   input  logic [AXI_DWIDTH-1:0] dn_data,
   input  logic                  dn_data_valid,
   output logic                  dn_data_ready
);

   localparam int                 OUT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CHUNK_W-1:0] MAX_LEN = CHUNK_W'(MAX_BURST_LEN);
   localparam logic [OUT_W-1:0]   MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   state_t                  state_reg;
   logic [AXI_AWIDTH-1:0]   cur_addr_reg;
   logic [31:0]             req_left_reg;
   logic [31:0]             beats_left_reg;
   logic [CHUNK_W-1:0]      chunk_reg;
   logic                    dn_req_valid_reg;
   logic [AXI_AWIDTH-1:0]   dn_addr_reg;
   logic [31:0]             dn_len_reg;
   logic                    xfer_done_reg;

   logic [AXI_AWIDTH-1:0]   start_addr;
   logic [CHUNK_W-1:0]      start_chunk;
   logic [AXI_AWIDTH-1:0]   issue_addr_next;
   logic [31:0]             issue_left_next;
   logic [CHUNK_W-1:0]      next_chunk;
   logic                    dn_hs;
   logic                    beat_counted;
   logic                    last_beat;
   logic                    final_beat;
   logic [OUT_W-1:0]        outstanding;
   logic [OUT_W-1:0]        outstanding_next;
   logic                    issue_room;

   function automatic logic [31:0] len_code(input logic [CHUNK_W-1:0] c);
      return (c == '0) ? 32'd0 : 32'(c) - 32'd1;
   endfunction

   // Read data is a pure wire path; the block only observes the handshake.
   assign up_data       = dn_data;
   assign up_data_valid = dn_data_valid;
   assign dn_data_ready = up_data_ready;

   assign up_req_ready = (state_reg == ST_IDLE);
   assign xfer_done    = xfer_done_reg;
   assign dn_req_valid = dn_req_valid_reg;
   assign dn_addr      = dn_addr_reg;
   assign dn_len       = dn_len_reg;
   assign dn_size      = AXI_SIZE_4B;
   assign dn_burst     = AXI_BURST_INCR;

   assign start_addr      = up_addr & ~AXI_AWIDTH'(3);
   assign start_chunk     = burst_chunk(start_addr[11:0], up_len, MAX_LEN);
   assign issue_addr_next = cur_addr_reg + AXI_AWIDTH'({chunk_reg, 2'b00});
   assign issue_left_next = req_left_reg - 32'(chunk_reg);
   assign next_chunk      = burst_chunk(issue_addr_next[11:0], issue_left_next, MAX_LEN);

   assign dn_hs        = dn_req_valid_reg && dn_req_ready;
   assign beat_counted = dn_data_valid && up_data_ready && (beats_left_reg != 32'd0);
   assign last_beat    = beat_counted && (beats_left_reg == 32'd1);

   // Valid is registered, so it must look ahead at next cycle's outstanding count.
   always_comb begin
      outstanding_next = outstanding;
      if (dn_hs && !final_beat)
         outstanding_next = outstanding + OUT_W'(1);
      else if (!dn_hs && final_beat)
         outstanding_next = outstanding - OUT_W'(1);
   end

   assign issue_room = (outstanding_next < MAX_OUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         cur_addr_reg     <= '0;
         req_left_reg     <= '0;
         beats_left_reg   <= '0;
         chunk_reg        <= '0;
         dn_req_valid_reg <= 1'b0;
         dn_addr_reg      <= '0;
         dn_len_reg       <= '0;
         xfer_done_reg    <= 1'b0;
      end else begin
         xfer_done_reg <= 1'b0;
         if (beat_counted)
            beats_left_reg <= beats_left_reg - 32'd1;
         case (state_reg)
            ST_IDLE: begin
               if (up_req_valid) begin
                  cur_addr_reg   <= start_addr;
                  dn_addr_reg    <= start_addr;
                  req_left_reg   <= up_len;
                  beats_left_reg <= up_len;
                  chunk_reg      <= start_chunk;
                  dn_len_reg     <= len_code(start_chunk);
                  if (up_len == 32'd0) begin
                     xfer_done_reg <= 1'b1;
                  end else begin
                     state_reg        <= ST_ISSUE;
                     dn_req_valid_reg <= issue_room;
                  end
               end
            end
            ST_ISSUE: begin
               if (dn_hs) begin
                  cur_addr_reg <= issue_addr_next;
                  dn_addr_reg  <= issue_addr_next;
                  req_left_reg <= issue_left_next;
                  chunk_reg    <= next_chunk;
                  dn_len_reg   <= len_code(next_chunk);
                  if (issue_left_next == 32'd0) begin
                     state_reg        <= ST_DRAIN;
                     dn_req_valid_reg <= 1'b0;
                  end else begin
                     dn_req_valid_reg <= issue_room;
                  end
               end else begin
                  dn_req_valid_reg <= issue_room;
               end
            end
            ST_DRAIN: begin
               if ((beats_left_reg == 32'd0) || last_beat) begin
                  xfer_done_reg <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   axi_read_burst_splitter_burst_len_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (CHUNK_W)
   ) u_burst_len_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (dn_hs),
      .push_count (chunk_reg),
      .beat       (beat_counted),
      .final_beat (final_beat),
      .count      (outstanding)
   );

endmodule

// File: tb/tb_axi_read_burst_splitter.sv
// Directed bench for the read burst splitter: burst splitting, 4 KB clipping,
// zero-length requests, outstanding limit, stalls, address wrap and async reset.
module tb_axi_read_burst_splitter;

   logic        clk;
   logic        rst;
   logic        up_req_valid;
   logic        up_req_ready;
   logic [31:0] up_addr;
   logic [31:0] up_len;
   logic [31:0] up_data;
   logic        up_data_valid;
   logic        up_data_ready;
   logic        xfer_done;
   logic        dn_req_valid;
   logic        dn_req_ready;
   logic [31:0] dn_addr;
   logic [31:0] dn_len;
   logic [2:0]  dn_size;
   logic [1:0]  dn_burst;
   logic [31:0] dn_data;
   logic        dn_data_valid;
   logic        dn_data_ready;

   int checks;
   int failures;

   // scoreboard state for the current transfer
   logic [31:0] burst_addr [16];
   logic [31:0] burst_len  [16];
   int          n_bursts;
   int          issued_beats;
   int          sent_beats;
   int          sent_at_done;
   int          done_cnt;
   int          data_err;
   int          stall_err;
   int          ready_err;
   int          valid_seen;
   logic        active;
   logic        stall_en;
   logic        data_en;
   logic        hold_valid;
   logic [31:0] hold_addr;
   logic [31:0] hold_len;

   axi_read_burst_splitter #(
      .AXI_AWIDTH      (32),
      .AXI_DWIDTH      (32),
      .MAX_BURST_LEN   (256),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .up_req_valid  (up_req_valid),
      .up_req_ready  (up_req_ready),
      .up_addr       (up_addr),
      .up_len        (up_len),
      .up_data       (up_data),
      .up_data_valid (up_data_valid),
      .up_data_ready (up_data_ready),
      .xfer_done     (xfer_done),
      .dn_req_valid  (dn_req_valid),
      .dn_req_ready  (dn_req_ready),
      .dn_addr       (dn_addr),
      .dn_len        (dn_len),
      .dn_size       (dn_size),
      .dn_burst      (dn_burst),
      .dn_data       (dn_data),
      .dn_data_valid (dn_data_valid),
      .dn_data_ready (dn_data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear();
      n_bursts     = 0;
      issued_beats = 0;
      sent_beats   = 0;
      sent_at_done = -1;
      done_cnt     = 0;
      data_err     = 0;
      stall_err    = 0;
      ready_err    = 0;
      valid_seen   = 0;
      active       = 1'b0;
      hold_valid   = 1'b0;
      hold_addr    = '0;
      hold_len     = '0;
   endtask

   // One clock of adapter/requester behaviour; entered and left at posedge+1.
   task automatic step();
      dn_req_ready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      up_data_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      dn_data_valid = data_en && (sent_beats < issued_beats) &&
                      (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
      dn_data       = 32'hD000_0000 + sent_beats;
      @(negedge clk);
      if (hold_valid && (!dn_req_valid || dn_addr !== hold_addr || dn_len !== hold_len))
         stall_err++;
      hold_valid = dn_req_valid && !dn_req_ready;
      hold_addr  = dn_addr;
      hold_len   = dn_len;
      if (dn_req_valid) valid_seen++;
      if (dn_req_valid && dn_req_ready) begin
         if (n_bursts < 16) begin
            burst_addr[n_bursts] = dn_addr;
            burst_len[n_bursts]  = dn_len;
         end
         n_bursts++;
         issued_beats += int'(dn_len) + 1;
      end
      if (dn_data_valid && up_data_ready) begin
         if (up_data !== (32'hD000_0000 + sent_beats) || up_data_valid !== 1'b1 ||
             dn_data_ready !== 1'b1)
            data_err++;
         sent_beats++;
      end
      if (active && done_cnt == 0 && !xfer_done && up_req_ready) ready_err++;
      if (xfer_done) begin
         if (done_cnt == 0) sent_at_done = sent_beats;
         done_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [31:0] a, input logic [31:0] n);
      int w;
      w = 0;
      up_addr       = a;
      up_len        = n;
      up_req_valid  = 1'b1;
      dn_data_valid = 1'b0;
      dn_req_ready  = 1'b0;
      @(negedge clk);
      while (!up_req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (up_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL req_accept: up_req_ready=%0b required 1", up_req_ready);
      end
      @(posedge clk);
      #1;
      up_req_valid = 1'b0;
      active       = 1'b1;
   endtask

   task automatic run_until_done(input int budget, input string name);
      int c;
      c = 0;
      while (done_cnt == 0 && c < budget) begin
         step();
         c++;
      end
      checks++;
      if (done_cnt == 0) begin
         failures++;
         $display("FAIL %s_timeout: no xfer_done within %0d cycles", name, budget);
      end
      repeat (4) step();
      $display("xfer %s: bursts=%0d beats=%0d done_pulses=%0d", name, n_bursts, sent_beats, done_cnt);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (up_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0b required 1", up_req_ready); end
      checks++; if (dn_req_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b required 0", dn_req_valid); end
      checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b required 0", xfer_done); end
      checks++; if (dn_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %0h required 0", dn_addr); end
      checks++; if (dn_len !== 32'h0) begin failures++; $display("FAIL rst_len: got %0h required 0", dn_len); end
      checks++; if (dn_size !== 3'b010 || dn_burst !== 2'b01) begin failures++; $display("FAIL rst_consts: size=%0b burst=%0b required 010/01", dn_size, dn_burst); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("xfer reset: checked idle outputs");
   endtask

   task automatic test_split_600();
      clear(); stall_en = 1'b0; data_en = 1'b1;
      request(32'h1000_0000, 600);
      run_until_done(2000, "split600");
      checks++; if (n_bursts !== 3) begin failures++; $display("FAIL s600_bursts: got %0d required 3", n_bursts); end
      checks++; if (burst_addr[0] !== 32'h1000_0000 || burst_len[0] !== 32'd255) begin failures++; $display("FAIL s600_b0: addr=%0h len=%0d required 10000000/255", burst_addr[0], burst_len[0]); end
      checks++; if (burst_addr[1] !== 32'h1000_0400 || burst_len[1] !== 32'd255) begin failures++; $display("FAIL s600_b1: addr=%0h len=%0d required 10000400/255", burst_addr[1], burst_len[1]); end
      checks++; if (burst_addr[2] !== 32'h1000_0800 || burst_len[2] !== 32'd87) begin failures++; $display("FAIL s600_b2: addr=%0h len=%0d required 10000800/87", burst_addr[2], burst_len[2]); end
      checks++; if (sent_beats !== 600 || data_err !== 0) begin failures++; $display("FAIL s600_data: beats=%0d errs=%0d required 600/0", sent_beats, data_err); end
      checks++; if (done_cnt !== 1 || sent_at_done !== 600) begin failures++; $display("FAIL s600_done: pulses=%0d at_beat=%0d required 1/600", done_cnt, sent_at_done); end
      checks++; if (ready_err !== 0) begin failures++; $display("FAIL s600_ready: early ready cycles=%0d required 0", ready_err); end
   endtask

   task automatic test_boundary();
      clear(); stall_en = 1'b0; data_en = 1'b1;
      request(32'h2000_0FF0, 10);
      run_until_done(200, "boundary");
      checks++; if (n_bursts !== 2) begin failures++; $display("FAIL bnd_bursts: got %0d required 2", n_bursts); end
      checks++; if (burst_addr[0] !== 32'h2000_0FF0 || burst_len[0] !== 32'd3) begin failures++; $display("FAIL bnd_b0: addr=%0h len=%0d required 20000ff0/3", burst_addr[0], burst_len[0]); end
      checks++; if (burst_addr[1] !== 32'h2000_1000 || burst_len[1] !== 32'd5) begin failures++; $display("FAIL bnd_b1: addr=%0h len=%0d required 20001000/5", burst_addr[1], burst_len[1]); end
      checks++; if (sent_beats !== 10 || done_cnt !== 1) begin failures++; $display("FAIL bnd_done: beats=%0d pulses=%0d required 10/1", sent_beats, done_cnt); end
   endtask

   task automatic test_zero_len();
      clear(); stall_en = 1'b0; data_en = 1'b1;
      request(32'h0000_1234, 0);
      @(negedge clk);
      checks++; if (xfer_done !== 1'b1) begin failures++; $display("FAIL zero_done1: got %0b required 1", xfer_done); end
      checks++; if (dn_req_valid !== 1'b0) begin failures++; $display("FAIL zero_valid: got %0b required 0", dn_req_valid); end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL zero_done2: got %0b required 0", xfer_done); end
      @(posedge clk);
      #1;
      repeat (5) step();
      checks++; if (valid_seen !== 0 || done_cnt !== 0) begin failures++; $display("FAIL zero_after: valid_cycles=%0d pulses=%0d required 0/0", valid_seen, done_cnt); end
      $display("xfer zero_len: done pulse checked");
   endtask

   task automatic test_outstanding();
      int c;
      clear(); stall_en = 1'b0; data_en = 1'b0;
      request(32'h3000_0000, 1024);
      repeat (10) step();
      checks++; if (n_bursts !== 2) begin failures++; $display("FAIL out_limit: bursts=%0d required 2", n_bursts); end
      checks++; if (dn_req_valid !== 1'b0) begin failures++; $display("FAIL out_valid_low: got %0b required 0", dn_req_valid); end
      data_en = 1'b1;
      c = 0;
      while (sent_beats < 256 && c < 600) begin
         step();
         c++;
      end
      checks++; if (sent_beats !== 256 || n_bursts !== 2) begin failures++; $display("FAIL out_first256: beats=%0d bursts=%0d required 256/2", sent_beats, n_bursts); end
      step();
      checks++; if (n_bursts !== 3 || burst_addr[2] !== 32'h3000_0800) begin failures++; $display("FAIL out_third: bursts=%0d addr=%0h required 3/30000800", n_bursts, burst_addr[2]); end
      run_until_done(3000, "outstanding");
      checks++; if (n_bursts !== 4 || burst_addr[3] !== 32'h3000_0C00 || burst_len[3] !== 32'd255) begin failures++; $display("FAIL out_fourth: bursts=%0d addr=%0h len=%0d required 4/30000c00/255", n_bursts, burst_addr[3], burst_len[3]); end
      checks++; if (sent_beats !== 1024 || data_err !== 0 || done_cnt !== 1) begin failures++; $display("FAIL out_total: beats=%0d errs=%0d pulses=%0d required 1024/0/1", sent_beats, data_err, done_cnt); end
   endtask

   task automatic test_stalls();
      clear(); stall_en = 1'b1; data_en = 1'b1;
      request(32'h6000_0F00, 300);
      run_until_done(5000, "stalls");
      stall_en = 1'b0;
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_stable: unstable cycles=%0d required 0", stall_err); end
      checks++; if (n_bursts !== 2 || burst_addr[0] !== 32'h6000_0F00 || burst_len[0] !== 32'd63) begin failures++; $display("FAIL stall_b0: bursts=%0d addr=%0h len=%0d required 2/60000f00/63", n_bursts, burst_addr[0], burst_len[0]); end
      checks++; if (burst_addr[1] !== 32'h6000_1000 || burst_len[1] !== 32'd235) begin failures++; $display("FAIL stall_b1: addr=%0h len=%0d required 60001000/235", burst_addr[1], burst_len[1]); end
      checks++; if (sent_beats !== 300 || data_err !== 0 || sent_at_done !== 300) begin failures++; $display("FAIL stall_beats: beats=%0d errs=%0d at_done=%0d required 300/0/300", sent_beats, data_err, sent_at_done); end
      checks++; if (done_cnt !== 1 || ready_err !== 0) begin failures++; $display("FAIL stall_done: pulses=%0d early_ready=%0d required 1/0", done_cnt, ready_err); end
   endtask

   task automatic test_wrap();
      clear(); stall_en = 1'b0; data_en = 1'b1;
      request(32'hFFFF_FFF8, 4);
      run_until_done(200, "wrap");
      checks++; if (n_bursts !== 2 || burst_addr[0] !== 32'hFFFF_FFF8 || burst_len[0] !== 32'd1) begin failures++; $display("FAIL wrap_b0: bursts=%0d addr=%0h len=%0d required 2/fffffff8/1", n_bursts, burst_addr[0], burst_len[0]); end
      checks++; if (burst_addr[1] !== 32'h0000_0000 || burst_len[1] !== 32'd1) begin failures++; $display("FAIL wrap_b1: addr=%0h len=%0d required 0/1", burst_addr[1], burst_len[1]); end
   endtask

   task automatic test_reset_mid_drain();
      int c;
      clear(); stall_en = 1'b0; data_en = 1'b0;
      request(32'h4000_0000, 8);
      repeat (3) step();
      data_en = 1'b1;
      c = 0;
      while (sent_beats < 3 && c < 20) begin
         step();
         c++;
      end
      dn_data_valid = 1'b0;
      checks++; if (n_bursts !== 1 || up_req_ready !== 1'b0) begin failures++; $display("FAIL mid_drain_state: bursts=%0d ready=%0b required 1/0", n_bursts, up_req_ready); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (up_req_ready !== 1'b1 || dn_req_valid !== 1'b0 || xfer_done !== 1'b0) begin failures++; $display("FAIL async_rst_ctrl: ready=%0b valid=%0b done=%0b required 1/0/0", up_req_ready, dn_req_valid, xfer_done); end
      checks++; if (dn_addr !== 32'h0 || dn_len !== 32'h0) begin failures++; $display("FAIL async_rst_regs: addr=%0h len=%0h required 0/0", dn_addr, dn_len); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("xfer reset_mid_drain: async reset applied");
      clear(); data_en = 1'b1;
      request(32'h5000_0010, 4);
      run_until_done(200, "after_reset");
      checks++; if (n_bursts !== 1 || burst_addr[0] !== 32'h5000_0010 || burst_len[0] !== 32'd3) begin failures++; $display("FAIL post_rst_burst: bursts=%0d addr=%0h len=%0d required 1/50000010/3", n_bursts, burst_addr[0], burst_len[0]); end
      checks++; if (sent_beats !== 4 || done_cnt !== 1 || data_err !== 0) begin failures++; $display("FAIL post_rst_done: beats=%0d pulses=%0d errs=%0d required 4/1/0", sent_beats, done_cnt, data_err); end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      up_req_valid  = 1'b0;
      up_addr       = '0;
      up_len        = '0;
      up_data_ready = 1'b1;
      dn_req_ready  = 1'b0;
      dn_data       = '0;
      dn_data_valid = 1'b0;
      stall_en      = 1'b0;
      data_en       = 1'b0;
      clear();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(posedge clk);
      #1;
      test_split_600();
      test_boundary();
      test_zero_len();
      test_outstanding();
      test_stalls();
      test_wrap();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_read_burst_splitter.md
Name: axi_read_burst_splitter

Overview:
Read-request conditioning stage between the memory arbiter's core read port and the AXI memory-mapped adapter. It accepts one arbitrarily long read (32-bit beat count) and issues a sequence of legal AXI INCR bursts. Each burst is at most MAX_BURST_LEN beats and never crosses a 4 KB boundary. Read data passes straight through; the block counts beats and pulses done when the whole transfer has returned.

Parameters:
AXI_AWIDTH, 32, address width
AXI_DWIDTH, 32, data width; beat = AXI_DWIDTH/8 bytes (4)
MAX_BURST_LEN, 256, max beats per emitted burst (1..256)
MAX_OUTSTANDING, 4, max bursts issued but not fully returned (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
up_req_valid  in  1  transfer request valid
up_req_ready  out  1  high in IDLE only
up_addr  in  AXI_AWIDTH  start byte address; bits [1:0] ignored (forced 0)
up_len  in  32  transfer length in beats (0 allowed)
up_data  out  AXI_DWIDTH  read data to requester
up_data_valid  out  1  read data valid
up_data_ready  in  1  requester accepts data
xfer_done  out  1  one-cycle pulse when the transfer completes
dn_req_valid  out  1  burst request to adapter
dn_req_ready  in  1  adapter accepts burst
dn_addr  out  AXI_AWIDTH  burst start address
dn_len  out  32  beats-1 of this burst (AXI encoding)
dn_size  out  3  constant 3'b010
dn_burst  out  2  constant 2'b01 (INCR)
dn_data  in  AXI_DWIDTH  adapter read data
dn_data_valid  in  1  adapter data valid
dn_data_ready  out  1  to adapter

Behaviour:
- Reset (async, any time, including mid-transfer): state=IDLE, all counters 0, up_req_ready=1, dn_req_valid=0, xfer_done=0, dn_addr=0, dn_len=0. Upstream and adapter must be reset together; in-flight beats are dropped.
- Data path is combinational passthrough: up_data=dn_data, up_data_valid=dn_data_valid, dn_data_ready=up_data_ready. No buffering and no added latency.
- Registers: cur_addr, req_left (beats not yet requested), beats_left (beats not yet returned), outstanding (bursts), last_burst_beats[]. A beat is counted on dn_data_valid & dn_data_ready.
- chunk = min(req_left, MAX_BURST_LEN, (4096 - cur_addr[11:0]) >> 2). Compute it with ≥13-bit intermediates; the 4 KB term is 1..1024.
- FSM:
  - IDLE: up_req_ready=1. On a handshake, latch addr, req_left=beats_left=up_len.
    - If up_len==0: assert xfer_done the next cycle and stay IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: dn_req_valid=1 only while outstanding < MAX_OUTSTANDING. dn_addr=cur_addr and dn_len=chunk-1, both driven from registers and stable while valid & !ready.
    - On a handshake: cur_addr += chunk*4, req_left -= chunk, outstanding++.
    - If chunk==req_left, go to DRAIN.
  - DRAIN: wait for beats_left==0, then pulse xfer_done for 1 cycle and return to IDLE. up_req_ready stays 0 until IDLE.
- Outstanding decrements when the final beat of the oldest burst returns. Track this with a small FIFO of burst beat counts, depth MAX_OUTSTANDING.
- Simultaneous request handshake and final-beat return: the net outstanding count is unchanged.
- A beat arriving while beats_left==0 is a protocol error and is ignored by the counters.
- Address wraps modulo 2^AXI_AWIDTH; no error is flagged.

Decomposition:
- Shared package/header: AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, BOUNDARY_BYTES=4096, FSM state encodings.
- One sub-module: burst_len_fifo, a sync FIFO of chunk counts (depth MAX_OUTSTANDING, width 9) that tracks the remaining beats of the oldest burst.

Test Plan:
- addr=0x1000_0000, len=600, dn_req_ready=1 -> exactly three bursts:
  - dn_addr 0x1000_0000 with dn_len 255
  - dn_addr 0x1000_0400 with dn_len 255
  - dn_addr 0x1000_0800 with dn_len 87
  - Then 600 data beats pass through in order and xfer_done pulses once after beat 600.
- addr=0x2000_0FF0, len=10 -> two bursts, and no burst crosses 4 KB:
  - 0x2000_0FF0 with dn_len 3
  - 0x2000_1000 with dn_len 5
- len=0 -> xfer_done is high exactly 1 cycle after accept, and dn_req_valid never asserts.
- MAX_OUTSTANDING=2, len=1024, no data returned -> only 2 bursts are issued. After 256 beats return, the 3rd burst issues the following cycle.
- Randomized stalls on dn_req_ready and up_data_ready -> dn_addr/dn_len stay stable while stalled, the beat count is exact, and up_req_ready stays low until after xfer_done.
- rst asserted mid-DRAIN -> all outputs take reset values immediately (async), and a new len=4 transfer completes normally.
